// File: rtl/reg_piso_tx.sv
// ---------------------------------------------------------------------------
// reg_piso_tx
// Parallel-in / serial-out transmitter for unloading a data register onto a
// 1-bit serial link. A word is taken over a valid/ready load handshake and
// shifted out one bit per accepted serial beat. The serial side can stall
// for any number of cycles. A new word can be taken on the final beat of the
// current word, so back-to-back words leave no idle cycle on the link.
//
// Ports
//   Clock       in   1      single clock, all state changes on posedge
//   Reset       in   1      synchronous, active-high
//   Load_Valid  in   1      Load_Data holds a word to transmit
//   Load_Ready  out  1      a word can be taken this cycle (depends on Ser_Ready)
//   Load_Data   in   WIDTH  parallel word
//   Ser_Data    out  1      current serial bit
//   Ser_Valid   out  1      Ser_Data is valid
//   Ser_Ready   in   1      consumer takes Ser_Data this cycle
//   Ser_Last    out  1      current bit is the final bit of the word
//   Busy        out  1      a word is loaded and not yet fully transmitted
//   Word_Count  out  CNT_W  number of fully transmitted words, wraps
// ---------------------------------------------------------------------------
module reg_piso_tx #(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load_Valid,
    output logic             Load_Ready,
    input  logic [WIDTH-1:0] Load_Data,
    output logic             Ser_Data,
    output logic             Ser_Valid,
    input  logic             Ser_Ready,
    output logic             Ser_Last,
    output logic             Busy,
    output logic [CNT_W-1:0] Word_Count
);

    localparam int BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0]     bcnt_q, bcnt_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               beat_s;
    logic               load_s;

    // In SHIFT Ser_Valid is always high, so a beat is simply SHIFT && Ser_Ready.
    assign beat_s     = (state_q == SHIFT) && Ser_Ready;
    // Ready in IDLE, or on the final beat so the next word follows without a bubble.
    assign Load_Ready = !Reset && ((state_q == IDLE) || (beat_s && last_q));
    assign load_s     = Load_Valid && Load_Ready;

    // Next-state logic: shift on a beat, then let a load override the result.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        if (beat_s) begin
            if (MSB_FIRST != 0) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            if (last_q) begin
                wcnt_d  = wcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                bcnt_d  = {BCW{1'b0}};
                state_d = IDLE;
            end else begin
                bcnt_d  = bcnt_q + {{(BCW-1){1'b0}}, 1'b1};
            end
        end else begin
            bcnt_d = bcnt_q;
        end
        if (load_s) begin
            shreg_d = Load_Data;
            bcnt_d  = {BCW{1'b0}};
            state_d = SHIFT;
        end else begin
            shreg_d = shreg_d;
        end
        // Ser_Last is registered: it is derived from the counter value being loaded.
        last_d = (state_d == SHIFT) && (bcnt_d == BCW'(WIDTH - 1));
    end

    // State registers with synchronous reset; a reset mid-word discards the word.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            shreg_q <= {WIDTH{1'b0}};
            bcnt_q  <= {BCW{1'b0}};
            last_q  <= 1'b0;
            wcnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign Ser_Data   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign Ser_Valid  = (state_q == SHIFT);
    assign Busy       = (state_q == SHIFT);
    assign Ser_Last   = last_q;
    assign Word_Count = wcnt_q;

endmodule
